tdc_hit_readout: RTL and testbench

TDC_HIT_READOUT -- requirements
Module: tdc_hit_readout

---
 rtl/tdc_readout_pkg.sv | 31 +++
 rtl/tdc_hit_readout_if.sv | 11 +
 rtl/tdc_hit_fifo.sv | 54 +++++
 rtl/tdc_hit_readout.sv | 146 ++++++++++++++
 tb/tb_tdc_hit_readout.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tdc_readout_pkg.sv
// Shared widths, word layout and helpers for the TDC hit readout.
package tdc_readout_pkg;

  // Per-channel code widths.
  localparam int unsigned ToaW  = 10;
  localparam int unsigned TotW  = 9;
  localparam int unsigned CalW  = 10;
  localparam int unsigned ErrW  = 3;
  localparam int unsigned CodeW = ToaW + TotW + CalW + ErrW;

  // Bit offsets of each field inside an output word {chID, BCID, TOA, TOT, Cal, err}.
  localparam int unsigned ErrLsb  = 0;
  localparam int unsigned CalLsb  = ErrLsb + ErrW;
  localparam int unsigned TotLsb  = CalLsb + CalW;
  localparam int unsigned ToaLsb  = TotLsb + TotW;
  localparam int unsigned BcidLsb = ToaLsb + ToaW;

  // Codes captured for one hit; packs in the same order as the low word bits.
  typedef struct packed {
    logic [ToaW-1:0] toa;
    logic [TotW-1:0] tot;
    logic [CalW-1:0] cal;
    logic [ErrW-1:0] err;
  } hitCodeT;

  // Width of one output word for a given channel count and BCID width.
  function automatic int unsigned wordWidth(int unsigned nch, int unsigned bcidW);
    return $clog2(nch) + bcidW + CodeW;
  endfunction

endpackage

// File: rtl/tdc_hit_readout_if.sv
// Valid/ready output stream carrying packed hit words.
interface tdc_hit_readout_if #(
  parameter int unsigned W = 46
);
  logic         dout_valid;
  logic         dout_ready;
  logic [W-1:0] dout_data;

  modport master (output dout_valid, output dout_data, input dout_ready);
  modport slave  (input dout_valid, input dout_data, output dout_ready);
endinterface

// File: rtl/tdc_hit_fifo.sv
// Synchronous show-ahead FIFO; head word is visible on rdData whenever not empty.
module tdc_hit_fifo #(
  parameter int unsigned W     = 46,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk40,
  input  logic                     resetn,
  input  logic                     wrEn,
  input  logic [W-1:0]             wrData,
  input  logic                     rdEn,
  output logic [W-1:0]             rdData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtrQ, rdPtrQ;
  logic [AW:0]   cntQ;
  logic          doWr, doRd;

  assign empty = (cntQ == '0);
  assign full  = (cntQ == (AW+1)'(DEPTH));
  assign doRd  = rdEn && !empty;
  // A write into a full FIFO is legal only when the head leaves on the same edge.
  assign doWr  = wrEn && (!full || doRd);
  assign level = cntQ;
  assign rdData = empty ? '0 : mem[rdPtrQ];

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk40) begin
    if (doWr) mem[wrPtrQ] <= wrData;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk40 or negedge resetn) begin
    if (!resetn) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      cntQ   <= '0;
    end else begin
      if (doWr) wrPtrQ <= wrPtrQ + 1'b1;
      if (doRd) rdPtrQ <= rdPtrQ + 1'b1;
      unique case ({doWr, doRd})
        2'b10:   cntQ <= cntQ + 1'b1;
        2'b01:   cntQ <= cntQ - 1'b1;
        default: cntQ <= cntQ;
      endcase
    end
  end

endmodule

// File: rtl/tdc_hit_readout.sv
// TDC hit readout: per-channel TOA filter, BCID tagging, one-deep pending
// registers, round-robin arbitration into a show-ahead output FIFO.
module tdc_hit_readout import tdc_readout_pkg::*; #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned BCID_W = 12
) (
  input  logic                    clk40,
  input  logic                    resetn,
  input  logic [NCH-1:0]          hitFlag,
  input  logic [NCH*ToaW-1:0]     TOA_code,
  input  logic [NCH*TotW-1:0]     TOT_code,
  input  logic [NCH*CalW-1:0]     Cal_code,
  input  logic [NCH*ErrW-1:0]     errFlag,
  input  logic                    filterEn,
  input  logic [ToaW-1:0]         toaLow,
  input  logic [ToaW-1:0]         toaHigh,
  input  logic                    bcReset,
  tdc_hit_readout_if.master       dout,
  output logic [7:0]              dropCnt,
  output logic [$clog2(DEPTH):0]  fifoLevel
);

  localparam int unsigned CHW   = $clog2(NCH);
  localparam int unsigned WordW = CHW + BCID_W + CodeW;

  logic [BCID_W-1:0]             bcidQ;
  logic [NCH-1:0]                pendValidQ, pendValidD;
  logic [NCH-1:0][BCID_W-1:0]    pendBcidQ, pendBcidD;
  hitCodeT [NCH-1:0]             pendCodeQ, pendCodeD;
  logic [CHW-1:0]                lastQ, lastD;
  logic [7:0]                    dropQ, dropD;

  logic [NCH-1:0]  hitAccept;
  logic [NCH-1:0]  grantOh;
  logic [CHW-1:0]  grantIdx, cand;
  logic            found, grantValid, canGrant;
  logic [4:0]      nDrop;
  logic [8:0]      dropSum;

  logic             fifoFull, fifoEmpty, rdEn;
  logic [WordW-1:0] fifoRdData, wrData;

  assign rdEn     = !fifoEmpty && dout.dout_ready;
  // Full FIFO can still take a word if the head leaves this cycle.
  assign canGrant = !fifoFull || rdEn;
  assign wrData   = {grantIdx, pendBcidQ[grantIdx], pendCodeQ[grantIdx]};

  // Bunch-crossing counter; wraps naturally, bcReset restarts it at zero.
  always_ff @(posedge clk40 or negedge resetn) begin
    if (!resetn)      bcidQ <= '0;
    else if (bcReset) bcidQ <= '0;
    else              bcidQ <= bcidQ + 1'b1;
  end

  // Per-channel acceptance: hit strobe qualified by the optional TOA window.
  always_comb begin
    hitAccept = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      hitAccept[k] = hitFlag[k] && (!filterEn ||
                     (TOA_code[ToaW*k +: ToaW] >= toaLow &&
                      TOA_code[ToaW*k +: ToaW] <= toaHigh));
    end
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    found    = 1'b0;
    grantIdx = '0;
    cand     = '0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      cand = CHW'((32'(lastQ) + i) % NCH);
      if (!found && pendValidQ[cand]) begin
        found    = 1'b1;
        grantIdx = cand;
      end
    end
    grantValid = found && canGrant;
    grantOh    = '0;
    if (grantValid) grantOh[grantIdx] = 1'b1;
    lastD = grantValid ? grantIdx : lastQ;
  end

  // Pending update: grant frees the slot, a new hit refills it; an occupied,
  // ungranted slot turns the new hit into a drop.
  always_comb begin
    pendValidD = pendValidQ;
    pendBcidD  = pendBcidQ;
    pendCodeD  = pendCodeQ;
    nDrop      = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (grantOh[k]) pendValidD[k] = 1'b0;
      if (hitAccept[k]) begin
        if (pendValidQ[k] && !grantOh[k]) begin
          nDrop = nDrop + 5'd1;
        end else begin
          pendValidD[k]    = 1'b1;
          pendBcidD[k]     = bcidQ;
          pendCodeD[k].toa = TOA_code[ToaW*k +: ToaW];
          pendCodeD[k].tot = TOT_code[TotW*k +: TotW];
          pendCodeD[k].cal = Cal_code[CalW*k +: CalW];
          pendCodeD[k].err = errFlag[ErrW*k +: ErrW];
        end
      end
    end
    dropSum = {1'b0, dropQ} + {4'b0, nDrop};
    dropD   = dropSum[8] ? 8'hFF : dropSum[7:0];
  end

  // Pending registers, arbiter pointer and drop counter.
  always_ff @(posedge clk40 or negedge resetn) begin
    if (!resetn) begin
      pendValidQ <= '0;
      pendBcidQ  <= '0;
      pendCodeQ  <= '0;
      lastQ      <= CHW'(NCH - 1);
      dropQ      <= '0;
    end else begin
      pendValidQ <= pendValidD;
      pendBcidQ  <= pendBcidD;
      pendCodeQ  <= pendCodeD;
      lastQ      <= lastD;
      dropQ      <= dropD;
    end
  end

  tdc_hit_fifo #(
    .W     (WordW),
    .DEPTH (DEPTH)
  ) uFifo (
    .clk40  (clk40),
    .resetn (resetn),
    .wrEn   (grantValid),
    .wrData (wrData),
    .rdEn   (rdEn),
    .rdData (fifoRdData),
    .full   (fifoFull),
    .empty  (fifoEmpty),
    .level  (fifoLevel)
  );

  assign dout.dout_valid = !fifoEmpty;
  assign dout.dout_data  = fifoRdData;
  assign dropCnt         = dropQ;

endmodule

// File: tb/tb_tdc_hit_readout.sv
// Directed self-checking bench for tdc_hit_readout (NCH=4, DEPTH=16, BCID_W=12).
module tb_tdc_hit_readout;
  import tdc_readout_pkg::*;

  localparam int unsigned NCH    = 4;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned BCID_W = 12;
  localparam int unsigned DW     = wordWidth(NCH, BCID_W);

  logic                clk40;
  logic                resetn;
  logic [NCH-1:0]      hitFlag;
  logic [NCH*ToaW-1:0] TOA_code;
  logic [NCH*TotW-1:0] TOT_code;
  logic [NCH*CalW-1:0] Cal_code;
  logic [NCH*ErrW-1:0] errFlag;
  logic                filterEn;
  logic [ToaW-1:0]     toaLow, toaHigh;
  logic                bcReset;
  logic [7:0]          dropCnt;
  logic [4:0]          fifoLevel;

  int nChecks = 0;
  int nErrors = 0;
  int unsigned toas[4] = '{99, 100, 200, 201};

  tdc_hit_readout_if #(.W(DW)) dout ();

  tdc_hit_readout #(
    .NCH    (NCH),
    .DEPTH  (DEPTH),
    .BCID_W (BCID_W)
  ) dut (
    .clk40     (clk40),
    .resetn    (resetn),
    .hitFlag   (hitFlag),
    .TOA_code  (TOA_code),
    .TOT_code  (TOT_code),
    .Cal_code  (Cal_code),
    .errFlag   (errFlag),
    .filterEn  (filterEn),
    .toaLow    (toaLow),
    .toaHigh   (toaHigh),
    .bcReset   (bcReset),
    .dout      (dout),
    .dropCnt   (dropCnt),
    .fifoLevel (fifoLevel)
  );

  initial clk40 = 1'b0;
  always #5 clk40 = ~clk40;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] makeWord(int unsigned ch, int unsigned bcid,
                                             int unsigned toa, int unsigned tot,
                                             int unsigned cal, int unsigned err);
    logic [DW-1:0] w;
    w = '0;
    w[BcidLsb+BCID_W +: 2]  = ch[1:0];
    w[BcidLsb +: BCID_W]    = bcid[BCID_W-1:0];
    w[ToaLsb +: ToaW]       = toa[ToaW-1:0];
    w[TotLsb +: TotW]       = tot[TotW-1:0];
    w[CalLsb +: CalW]       = cal[CalW-1:0];
    w[ErrLsb +: ErrW]       = err[ErrW-1:0];
    return w;
  endfunction

  task automatic tick();
    @(posedge clk40);
    #1;
  endtask

  task automatic setHit(input int unsigned ch, input int unsigned toa, input int unsigned tot,
                        input int unsigned cal, input int unsigned err);
    hitFlag[ch]              = 1'b1;
    TOA_code[ToaW*ch +: ToaW] = toa[ToaW-1:0];
    TOT_code[TotW*ch +: TotW] = tot[TotW-1:0];
    Cal_code[CalW*ch +: CalW] = cal[CalW-1:0];
    errFlag[ErrW*ch +: ErrW]  = err[ErrW-1:0];
  endtask

  // After this returns, a hit driven now is sampled with BCID = n.
  task automatic syncBcid(input int n);
    bcReset = 1'b1;
    tick();
    bcReset = 1'b0;
    repeat (n) tick();
  endtask

  task automatic popWord();
    dout.dout_ready = 1'b1;
    tick();
    dout.dout_ready = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; hitFlag = '0; TOA_code = '0; TOT_code = '0; Cal_code = '0; errFlag = '0;
    filterEn = 1'b0; toaLow = '0; toaHigh = '0; bcReset = 1'b0; dout.dout_ready = 1'b0;

    // Reset state
    #7;
    checkVal("rst_valid", dout.dout_valid, 0);
    checkVal("rst_data", dout.dout_data, 0);
    checkVal("rst_level", fifoLevel, 0);
    checkVal("rst_drop", dropCnt, 0);
    repeat (2) tick();
    resetn = 1'b1;
    tick();

    // All channels in one cycle: ch0..ch3 on consecutive cycles, same BCID
    dout.dout_ready = 1'b1;
    syncBcid(20);
    for (int k = 0; k < 4; k++) setHit(k, 400 + k, 10 + k, 500 + k, k);
    tick();
    hitFlag = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checkVal($sformatf("all_ch%0d", k), dout.dout_data, makeWord(k, 20, 400 + k, 10 + k, 500 + k, k));
    end
    tick();
    checkVal("all_empty", dout.dout_valid, 0);

    // Single hit latency and one-cycle valid
    syncBcid(5);
    setHit(2, 300, 171, 682, 5);
    tick();
    hitFlag = '0;
    checkVal("lat_e0_valid", dout.dout_valid, 0);
    tick();
    checkVal("lat_e1_valid", dout.dout_valid, 1);
    checkVal("lat_e1_data", dout.dout_data, makeWord(2, 5, 300, 171, 682, 5));
    tick();
    checkVal("lat_e2_valid", dout.dout_valid, 0);
    checkVal("lat_e2_data", dout.dout_data, 0);

    // TOA window boundaries: 99 and 201 rejected, 100 and 200 kept
    dout.dout_ready = 1'b0;
    filterEn = 1'b1; toaLow = 10'd100; toaHigh = 10'd200;
    syncBcid(10);
    for (int i = 0; i < 4; i++) begin
      setHit(1, toas[i], 3, 4, 0);
      tick();
    end
    hitFlag = '0;
    repeat (2) tick();
    checkVal("win_level", fifoLevel, 2);
    checkVal("win_first", dout.dout_data, makeWord(1, 11, 100, 3, 4, 0));
    popWord();
    checkVal("win_second", dout.dout_data, makeWord(1, 12, 200, 3, 4, 0));
    popWord();
    checkVal("win_empty", dout.dout_valid, 0);
    checkVal("win_nodrop", dropCnt, 0);
    filterEn = 1'b0;

    // Backpressure: full FIFO, one pending, three drops, in-order drain
    syncBcid(30);
    for (int i = 0; i < 20; i++) begin
      setHit(0, i, 1, 2, 0);
      tick();
    end
    hitFlag = '0;
    checkVal("bp_level", fifoLevel, 16);
    checkVal("bp_drop", dropCnt, 3);
    tick();
    checkVal("bp_level_hold", fifoLevel, 16);
    dout.dout_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      checkVal($sformatf("bp_word%0d", i), dout.dout_data, makeWord(0, 30 + i, i, 1, 2, 0));
      tick();
      if (i == 0) checkVal("bp_level_refill", fifoLevel, 16);
    end
    checkVal("bp_empty", dout.dout_valid, 0);

    // BCID wrap, and grant plus new hit on the same channel without a drop
    syncBcid(4095);
    setHit(3, 7, 1, 1, 1);
    tick();
    setHit(3, 8, 1, 1, 1);
    tick();
    hitFlag = '0;
    checkVal("wrap_4095", dout.dout_data, makeWord(3, 4095, 7, 1, 1, 1));
    tick();
    checkVal("wrap_0", dout.dout_data, makeWord(3, 0, 8, 1, 1, 1));
    tick();
    checkVal("wrap_empty", dout.dout_valid, 0);
    checkVal("wrap_nodrop", dropCnt, 3);

    // bcReset at BCID 77 tags the following hit with 0
    syncBcid(77);
    bcReset = 1'b1;
    tick();
    bcReset = 1'b0;
    setHit(1, 50, 2, 3, 4);
    tick();
    hitFlag = '0;
    tick();
    checkVal("bcrst_word", dout.dout_data, makeWord(1, 0, 50, 2, 3, 4));
    tick();
    checkVal("bcrst_empty", dout.dout_valid, 0);

    // Asynchronous reset with eight buffered words
    dout.dout_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      setHit(2, i, 0, 0, 0);
      tick();
    end
    hitFlag = '0;
    tick();
    checkVal("ar_level_pre", fifoLevel, 8);
    #2;
    resetn = 1'b0;
    #1;
    checkVal("ar_valid", dout.dout_valid, 0);
    checkVal("ar_level", fifoLevel, 0);
    checkVal("ar_drop", dropCnt, 0);
    checkVal("ar_data", dout.dout_data, 0);
    repeat (2) tick();
    resetn = 1'b1;
    dout.dout_ready = 1'b1;
    repeat (4) tick();
    checkVal("ar_quiet", dout.dout_valid, 0);
    setHit(0, 9, 0, 0, 0);
    tick();
    hitFlag = '0;
    tick();
    checkVal("ar_newhit", dout.dout_valid, 1);
    tick();
    checkVal("ar_final_empty", dout.dout_valid, 0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
